btn_pulse_gen: RTL and testbench
================================

Name: btn_pulse_gen

Overview:
- Upstream conditioning stage for the EGO1 pulse-mode sequential circuit exercises.
- Takes three raw push buttons and emits clean, debounced, strictly non-overlapping pulses on x1/x2/x3. These feed the pulse-mode state machine.
- Enforces the pulse-mode input rules: only one input pulse active at a time, with a guaranteed idle gap between pulses so the next-state logic settles.
- Presses arriving during a pulse or gap are buffered and served later in priority order.

Parameters:
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a level change (10 ms at 100 MHz).
- PULSE_W, 1, width in clk cycles of each emitted x pulse (>=1).
- GAP, 4, minimum all-low cycles after a pulse before the next pulse (>=1).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rd  in  1  reset, asynchronous, active-low.
- btn  in  3  raw buttons, asynchronous to clk; bit0 = x1, bit1 = x2, bit2 = x3.
- x1  out  1  pulse for button 0.
- x2  out  1  pulse for button 1.
- x3  out  1  pulse for button 2.
- busy  out  1  high when the FSM is not IDLE or any press is pending.

Behaviour:
- Reset (rd=0, asynchronous): synchronizers, stable levels, counters and the pending register are all cleared; FSM goes to IDLE; x1, x2, x3 and busy are driven 0 immediately.
  - Reset mid-pulse truncates the pulse at once.
  - Pending presses are discarded.
- Per button, in the btn_debounce sub-module:
  - 2-FF synchronizer (s1, s2), a stable level register, and a counter of width $clog2(DB_CYCLES+1).
  - Counter clears whenever s2 == stable.
  - Counter increments when s2 != stable.
  - On the edge where the counter reaches DB_CYCLES: stable <= s2, counter clears.
  - Glitches shorter than DB_CYCLES cycles never change stable.
- Rising edge of stable (0->1) sets pend[i] on the same clock edge. Falling edges are ignored.
- A button held through reset release is treated as a new press once DB_CYCLES have elapsed.
- Pending register pend[2:0]:
  - A set and a clear of the same bit on the same edge leaves the bit set (set wins).
  - A press on a bit that is already pending is merged; only one pulse is emitted.
- FSM states:
  - IDLE: if pend != 0, select the lowest set index (x1 > x2 > x3), clear that pend bit, drive that x high, and go to PULSE with width counter = 1. Otherwise stay in IDLE.
  - PULSE: hold the selected x high. When the counter reaches PULSE_W, drive x low and go to GAP.
  - GAP: all x low for GAP cycles, then go to IDLE. New presses are only recorded in pend.
- Outputs x1, x2, x3 are registered; at most one is high in any cycle.
- Latency: counting the first clk edge sampling btn=1 as edge 0:
  - stable and pend update at edge DB_CYCLES+1;
  - x goes high after edge DB_CYCLES+2.
- Spacing: back-to-back pending pulses have rising edges exactly PULSE_W+GAP+1 cycles apart.

Optional Feature:
- Macro BTN_PULSE_CNT_EN.
- When defined: adds output pulse_cnt [7:0].
  - Reset to 0.
  - Increments by 1 on every IDLE->PULSE transition.
  - Wraps 255->0.
  - Intended for the EGO1 LEDs.
- When undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package btn_pulse_pkg holds:
  - FSM state encodings: IDLE=2'd0, PULSE=2'd1, GAP=2'd2.
  - Button index constants BTN_X1=0, BTN_X2=1, BTN_X3=2.
- Sub-module btn_debounce, one instance per button. It contains the synchronizer, counter and stable level, and outputs stable plus a one-cycle rise strobe.
- The top level holds pend, the FSM and the optional counter.

Test Plan:
(all cases DB_CYCLES=4, PULSE_W=1, GAP=2)
- Reset: rd=0 with btn=3'b111 -> x1=x2=x3=busy=0 throughout. Release rd with btn=3'b001 held -> x1 high exactly after edge 6, for 1 cycle.
- Glitch rejection: btn[1] high for 3 cycles, then low -> no x2 pulse, busy stays 0.
- Simultaneous press: btn=3'b111 on one edge and held -> x1, then x2, then x3, rising edges 4 cycles apart, never overlapping.
- Merge/buffer: press btn[2], release, re-press during its PULSE/GAP window (stable clean transitions) -> second x3 pulse emitted after GAP. A double press while pend[2] is already set -> single x3.
- Reset mid-operation: assert rd while x2=1 and pend[0]=1 -> x2 drops asynchronously; after release, no x1 pulse is emitted.
- With BTN_PULSE_CNT_EN: 257 single presses -> pulse_cnt = 1.

Source files
------------

// File: rtl/btn_pulse_pkg.sv
// +----------------------------------------------------------------------+
// | btn_pulse_pkg : shared FSM encodings and button indices              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package btn_pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int BTN_X1  = 0;
  localparam int BTN_X2  = 1;
  localparam int BTN_X3  = 2;
  localparam int NUM_BTN = 3;

  // Isolates the lowest set bit, which is the highest-priority request.
  function automatic logic [NUM_BTN-1:0] lowest_one(input logic [NUM_BTN-1:0] v);
    return v & (~v + {{(NUM_BTN-1){1'b0}}, 1'b1});
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// +----------------------------------------------------------------------+
// | btn_debounce : 2-FF synchronizer + stability counter for one button  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rd,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] c_one      = CW'(1);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_done;

  // The level is accepted on the edge that would bring the count to DB_CYCLES.
  assign w_done = (r_s2 != r_stable) && (r_cnt == c_cnt_last);

  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + c_one;
      end
    end
  end

  assign o_stable = r_stable;
  assign o_rise   = w_done & r_s2;

endmodule

`default_nettype wire

// File: rtl/btn_pulse_gen.sv
// +----------------------------------------------------------------------+
// | btn_pulse_gen : debounced, non-overlapping pulse generator x1/x2/x3  |
// | Optional macro BTN_PULSE_CNT_EN adds pulse_cnt[7:0].  Rev 1.0        |
// +----------------------------------------------------------------------+
`default_nettype none

module btn_pulse_gen
  import btn_pulse_pkg::*;
#(
  parameter int DB_CYCLES = 1000000,
  parameter int PULSE_W   = 1,
  parameter int GAP       = 4
) (
  input  logic       clk,
  input  logic       rd,
  input  logic [2:0] btn,
  output logic       x1,
  output logic       x2,
  output logic       x3,
`ifdef BTN_PULSE_CNT_EN
  output logic [7:0] pulse_cnt,
`endif
  output logic       busy
);

  localparam int CNT_MAX = (PULSE_W > GAP) ? PULSE_W : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] c_one     = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_pulse_w = CNT_W'(PULSE_W);
  localparam logic [CNT_W-1:0] c_gap     = CNT_W'(GAP);

  logic [NUM_BTN-1:0] w_stable;
  logic [NUM_BTN-1:0] w_rise;
  logic               w_unused_stable;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk      (clk),
      .rd       (rd),
      .i_btn    (btn[gi]),
      .o_stable (w_stable[gi]),
      .o_rise   (w_rise[gi])
    );
  end

  assign w_unused_stable = ^w_stable;

  state_t             r_state, w_state_nx;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nx;
  logic [NUM_BTN-1:0] r_pend, w_pend_clr, w_sel;
  logic [NUM_BTN-1:0] r_x, w_x_nx;

  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_x     <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      // A new rise wins over a same-edge clear so no press is lost.
      r_pend  <= (r_pend & ~w_pend_clr) | w_rise;
      r_x     <= w_x_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_x_nx     = r_x;
    w_pend_clr = '0;
    w_sel      = lowest_one(r_pend);
    case (r_state)
      ST_IDLE: begin
        if (|r_pend) begin
          w_pend_clr = w_sel;
          w_x_nx     = w_sel;
          w_state_nx = ST_PULSE;
          w_cnt_nx   = c_one;
        end
      end
      ST_PULSE: begin
        if (r_cnt == c_pulse_w) begin
          w_x_nx     = '0;
          w_state_nx = ST_GAP;
          w_cnt_nx   = c_one;
        end else begin
          w_cnt_nx = r_cnt + c_one;
        end
      end
      ST_GAP: begin
        w_x_nx = '0;
        if (r_cnt == c_gap) begin
          w_state_nx = ST_IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + c_one;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_cnt_nx   = '0;
        w_x_nx     = '0;
      end
    endcase
  end

`ifdef BTN_PULSE_CNT_EN
  logic [7:0] r_pulse_cnt;

  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      r_pulse_cnt <= 8'd0;
    end else if ((r_state == ST_IDLE) && (w_state_nx == ST_PULSE)) begin
      r_pulse_cnt <= r_pulse_cnt + 8'd1;
    end
  end

  assign pulse_cnt = r_pulse_cnt;
`endif

  assign x1   = r_x[BTN_X1];
  assign x2   = r_x[BTN_X2];
  assign x3   = r_x[BTN_X3];
  assign busy = (r_state != ST_IDLE) || (|r_pend);

endmodule

`default_nettype wire

// File: tb/tb_btn_pulse_gen.sv
// +----------------------------------------------------------------------+
// | tb_btn_pulse_gen : directed bench with an expected-pulse scoreboard  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_btn_pulse_gen;

  localparam int DB = 4;
  localparam int PW = 1;
  localparam int GP = 2;

  logic       clk = 1'b0;
  logic       rd  = 1'b0;
  logic [2:0] btn = 3'b000;
  logic       x1, x2, x3, busy;
`ifdef BTN_PULSE_CNT_EN
  logic [7:0] pulse_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] prev_x = 3'b000;

  btn_pulse_gen #(.DB_CYCLES(DB), .PULSE_W(PW), .GAP(GP)) dut (
    .clk       (clk),
    .rd        (rd),
    .btn       (btn),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
`ifdef BTN_PULSE_CNT_EN
    .pulse_cnt (pulse_cnt),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_pulse(input int ch, input int c);
    sb.push_back('{ch, c});
  endtask

  // Each rising edge of an x output is matched against the oldest expected pulse.
  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] xv;
    xv = {x3, x2, x1};
    if (!rd) begin
      prev_x = 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (xv[i] && !prev_x[i]) begin
          chk("onehot", 32'($countones(xv)), 32'd1);
          chk("pulse_expected", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("pulse_channel", i, e.ch);
            chk("pulse_cycle", cyc, e.cyc);
          end
        end
      end
      prev_x = xv;
    end
  end

  initial begin
    int d;

    // Reset held with all buttons pressed
    rd  = 1'b0;
    btn = 3'b111;
    repeat (8) begin
      @(negedge clk);
      chk("rst_x", {29'd0, x3, x2, x1}, 0);
      chk("rst_busy", busy, 0);
    end
    @(negedge clk);
    d   = cyc;
    btn = 3'b001;
    rd  = 1'b1;
    expect_pulse(0, d + 7);
    repeat (4) @(negedge clk);
    btn = 3'b000;
    repeat (16) @(negedge clk);
    chk("rst_sb_empty", sb.size(), 0);

    // Glitch shorter than DB cycles
    @(negedge clk);
    btn = 3'b010;
    repeat (3) @(negedge clk);
    btn = 3'b000;
    repeat (12) begin
      @(negedge clk);
      chk("glitch_busy", busy, 0);
    end

    // Simultaneous press; x3 re-press rises on the edge its pend bit is cleared
    @(negedge clk);
    d   = cyc;
    btn = 3'b111;
    expect_pulse(0, d + 7);
    expect_pulse(1, d + 11);
    expect_pulse(2, d + 15);
    expect_pulse(2, d + 19);
    repeat (4) @(negedge clk);
    btn = 3'b000;
    repeat (5) @(negedge clk);
    btn = 3'b100;
    repeat (6) @(negedge clk);
    btn = 3'b000;
    repeat (20) @(negedge clk);
    chk("simul_sb_empty", sb.size(), 0);
    chk("simul_busy", busy, 0);

    // Second x3 press while pend[2] is still set merges into one pulse
    @(negedge clk);
    d   = cyc;
    btn = 3'b111;
    expect_pulse(0, d + 7);
    expect_pulse(1, d + 11);
    expect_pulse(2, d + 15);
    repeat (4) @(negedge clk);
    btn = 3'b000;
    repeat (4) @(negedge clk);
    btn = 3'b100;
    repeat (4) @(negedge clk);
    btn = 3'b000;
    repeat (25) @(negedge clk);
    chk("merge_sb_empty", sb.size(), 0);

    // Reset while x2 is high and x1 is pending
    @(negedge clk);
    d   = cyc;
    btn = 3'b010;
    expect_pulse(1, d + 7);
    @(negedge clk);
    btn = 3'b011;
    repeat (6) @(negedge clk);
    #1;
    chk("mid_x2_high", x2, 1);
    chk("mid_busy_high", busy, 1);
    rd  = 1'b0;
    btn = 3'b000;
    #1;
    chk("mid_x2_drop", x2, 0);
    chk("mid_x1_low", x1, 0);
    chk("mid_busy_drop", busy, 0);
    repeat (3) @(negedge clk);
    rd = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_sb_empty", sb.size(), 0);
    chk("mid_busy", busy, 0);

`ifdef BTN_PULSE_CNT_EN
    chk("cnt_reset", pulse_cnt, 0);
    for (int n = 0; n < 257; n++) begin
      @(negedge clk);
      d   = cyc;
      btn = 3'b001;
      expect_pulse(0, d + 7);
      repeat (4) @(negedge clk);
      btn = 3'b000;
      repeat (7) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("cnt_wrap", pulse_cnt, 1);
    chk("cnt_sb_empty", sb.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
